// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multicycle RV32I controller: FSM states, datapath mux selects,
// ALU operations, immediate formats and the per-state control word.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL, JALR_ADR
    } state_t;

    typedef enum logic       {ADR_PC, ADR_ALUOUT}          AdrSrc_t;
    typedef enum logic [1:0] {A_PC, A_OLDPC, A_RD1}         SrcA_t;
    typedef enum logic [1:0] {B_RD2, B_IMM, B_FOUR}         SrcB_t;
    typedef enum logic [1:0] {RES_ALUOUT, RES_DATA, RES_ALU} ResultSource_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
    } ALUop_t;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} IMM_t;

    // Coarse ALU request from the FSM; FUNCT defers to the instruction fields.
    typedef enum logic [1:0] {AOP_ADD, AOP_SUB, AOP_FUNCT} AluOpSel_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic          mem_req;
        logic          mem_write;
        AdrSrc_t       adr_src;
        SrcA_t         src_a;
        SrcB_t         src_b;
        ResultSource_t result_src;
        AluOpSel_t     alu_op;
        logic          reg_write;
        logic          pc_write;
    } ctl_t;

    // Moore part of the control word; input-gated strobes are added in the top.
    function automatic ctl_t state_ctl(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_req    = 1'b1;
                c.adr_src    = ADR_PC;
                c.src_a      = A_PC;
                c.src_b      = B_FOUR;
                c.result_src = RES_ALU;
                c.alu_op     = AOP_ADD;
            end
            DECODE: begin
                c.src_a  = A_OLDPC;
                c.src_b  = B_IMM;
                c.alu_op = AOP_ADD;
            end
            MEMADR, JALR_ADR: begin
                c.src_a  = A_RD1;
                c.src_b  = B_IMM;
                c.alu_op = AOP_ADD;
            end
            MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = ADR_ALUOUT;
            end
            MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.adr_src   = ADR_ALUOUT;
            end
            MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            EXECR: begin
                c.src_a  = A_RD1;
                c.src_b  = B_RD2;
                c.alu_op = AOP_FUNCT;
            end
            EXECI: begin
                c.src_a  = A_RD1;
                c.src_b  = B_IMM;
                c.alu_op = AOP_FUNCT;
            end
            ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            BRANCH: begin
                c.src_a      = A_RD1;
                c.src_b      = B_RD2;
                c.alu_op     = AOP_SUB;
                c.result_src = RES_ALUOUT;
            end
            JAL: begin
                c.src_a      = A_OLDPC;
                c.src_b      = B_FOUR;
                c.alu_op     = AOP_ADD;
                c.result_src = RES_ALUOUT;
                c.pc_write   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic IMM_t imm_decode(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_dec.sv
// ALU operation decoder: maps the FSM request plus funct3/funct7 to an ALU op and
// flags R-type funct7 encodings the core does not implement.
module alu_dec
    import mc_ctrl_pkg::*;
(
    input  AluOpSel_t  alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       opcode5,
    output ALUop_t     alu_control,
    output logic       bad_funct
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        alu_control = ALU_ADD;
        bad_funct   = 1'b0;
        case (alu_op)
            AOP_ADD: alu_control = ALU_ADD;
            AOP_SUB: alu_control = ALU_SUB;
            default: begin
                case (funct3)
                    // funct7[5] is immediate data for addi, so SUB needs the R-type bit too.
                    3'b000:  alu_control = (opcode5 && funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
                bad_funct = opcode5 && (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core: registers the state and its Moore
// control word, then adds the mem_ready/zero gated strobes and reset masking.
module multicycle_controller
    import mc_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [6:0]    opcode,
    input  logic [2:0]    funct3,
    input  logic [6:0]    funct7,
    input  logic          zero,
    input  logic          mem_ready,
    output logic          mem_req,
    output logic          mem_write,
    output AdrSrc_t       adr_src,
    output logic          ir_write,
    output logic          pc_write,
    output logic          reg_write,
    output SrcA_t         alu_src_a,
    output SrcB_t         alu_src_b,
    output ResultSource_t result_src,
    output ALUop_t        alu_control,
    output IMM_t          imm_src,
    output logic          illegal
);

    state_t state, next_state;
    ctl_t   ctl;
    logic   bad_funct;
    logic   known_op;
    logic   branch_taken;
    logic   branch_bad;

    always_comb begin
        known_op     = 1'b1;
        branch_taken = 1'b0;
        branch_bad   = 1'b0;
        next_state   = state;

        case (funct3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = !zero;
            default: branch_bad   = 1'b1;
        endcase

        case (state)
            FETCH:    if (mem_ready) next_state = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = MEMADR;
                    OP_R:              next_state = EXECR;
                    OP_I:              next_state = EXECI;
                    OP_BRANCH:         next_state = BRANCH;
                    OP_JAL:            next_state = JAL;
                    OP_JALR:           next_state = JALR_ADR;
                    default: begin
                        known_op   = 1'b0;
                        next_state = FETCH;
                    end
                endcase
            end
            MEMADR:   next_state = opcode[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (mem_ready) next_state = MEMWB;
            MEMWRITE: if (mem_ready) next_state = FETCH;
            EXECR:    next_state = bad_funct ? FETCH : ALUWB;
            EXECI:    next_state = ALUWB;
            JAL:      next_state = ALUWB;
            JALR_ADR: next_state = JAL;
            default:  next_state = FETCH;
        endcase
    end

    // Control word is registered with the state it belongs to, so both flip together.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            ctl   <= state_ctl(FETCH);
        end else begin
            state <= next_state;
            ctl   <= state_ctl(next_state);
        end
    end

    alu_dec u_alu_dec (
        .alu_op      (ctl.alu_op),
        .funct3      (funct3),
        .funct7      (funct7),
        .opcode5     (opcode[5]),
        .alu_control (alu_control),
        .bad_funct   (bad_funct)
    );

    assign adr_src    = ctl.adr_src;
    assign alu_src_a  = ctl.src_a;
    assign alu_src_b  = ctl.src_b;
    assign result_src = ctl.result_src;
    assign imm_src    = imm_decode(opcode);

    // Strobes are masked by rst so a reset cycle can never commit a write.
    assign mem_req   = !rst && ctl.mem_req;
    assign mem_write = !rst && ctl.mem_write;
    assign reg_write = !rst && ctl.reg_write;
    assign ir_write  = !rst && (state == FETCH) && mem_ready;
    assign pc_write  = !rst && (ctl.pc_write
                                || ((state == FETCH) && mem_ready)
                                || ((state == BRANCH) && branch_taken));
    assign illegal   = !rst && (((state == DECODE) && !known_op)
                                || ((state == EXECR) && bad_funct)
                                || ((state == BRANCH) && branch_bad));

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: each test queues per-cycle stimulus and expected outputs,
// then the queue is drained one clock at a time and compared against the DUT.
module tb_multicycle_controller;
    import mc_ctrl_pkg::*;

    // Strobe vector order: mem_req, mem_write, ir_write, pc_write, reg_write, illegal
    localparam logic [5:0] S_NONE    = 6'b000000;
    localparam logic [5:0] S_REQ     = 6'b100000;
    localparam logic [5:0] S_STORE   = 6'b110000;
    localparam logic [5:0] S_FETCHED = 6'b101100;
    localparam logic [5:0] S_PCW     = 6'b000100;
    localparam logic [5:0] S_REGW    = 6'b000010;
    localparam logic [5:0] S_ILL     = 6'b000001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    opcode = '0;
    logic [2:0]    funct3 = '0;
    logic [6:0]    funct7 = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_write, ir_write, pc_write, reg_write, illegal;
    AdrSrc_t       adr_src;
    SrcA_t         alu_src_a;
    SrcB_t         alu_src_b;
    ResultSource_t result_src;
    ALUop_t        alu_control;
    IMM_t          imm_src;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_write   (mem_write),
        .adr_src     (adr_src),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .alu_control (alu_control),
        .imm_src     (imm_src),
        .illegal     (illegal)
    );

    typedef struct {
        string         nm;
        logic [31:0]   ir;
        logic          rdy;
        logic          z;
        logic          r;
        logic [5:0]    strb;
        logic          alu_c;
        SrcA_t         a;
        SrcB_t         b;
        ALUop_t        alu;
        logic          res_c;
        ResultSource_t res;
        logic          adr_c;
        AdrSrc_t       adr;
        logic          imm_c;
        IMM_t          imm;
    } cyc_t;

    cyc_t        sb[$];
    logic [31:0] cur_ir = 32'h0000_0013;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
        return {f7, 10'b0, f3, 5'b0, op};
    endfunction

    function automatic cyc_t new_cyc(input string nm, input logic rdy, input logic z, input logic [5:0] strb);
        cyc_t c;
        c.nm = nm;   c.ir = cur_ir; c.rdy = rdy; c.z = z; c.r = 1'b0; c.strb = strb;
        c.alu_c = 1'b0; c.a = A_PC; c.b = B_RD2; c.alu = ALU_ADD;
        c.res_c = 1'b0; c.res = RES_ALUOUT;
        c.adr_c = 1'b0; c.adr = ADR_PC;
        c.imm_c = 1'b0; c.imm = IMM_I;
        return c;
    endfunction

    task automatic t_fetch(input string nm, input logic [31:0] instr, input int waits);
        cyc_t c;
        for (int i = 0; i <= waits; i++) begin
            c = new_cyc({nm, ".fetch"}, i == waits, 1'b0, (i == waits) ? S_FETCHED : S_REQ);
            c.alu_c = 1'b1; c.a = A_PC; c.b = B_FOUR; c.alu = ALU_ADD;
            c.res_c = 1'b1; c.res = RES_ALU;
            c.adr_c = 1'b1; c.adr = ADR_PC;
            sb.push_back(c);
        end
        cur_ir = instr;
    endtask

    task automatic t_dec(input string nm, input logic [5:0] strb, input logic imm_c, input IMM_t imm);
        cyc_t c;
        c = new_cyc({nm, ".dec"}, 1'b1, 1'b0, strb);
        c.alu_c = 1'b1; c.a = A_OLDPC; c.b = B_IMM; c.alu = ALU_ADD;
        c.imm_c = imm_c; c.imm = imm;
        sb.push_back(c);
    endtask

    task automatic t_alu(input string nm, input logic [5:0] strb, input SrcA_t a, input SrcB_t b, input ALUop_t alu);
        cyc_t c;
        c = new_cyc(nm, 1'b1, 1'b0, strb);
        c.alu_c = 1'b1; c.a = a; c.b = b; c.alu = alu;
        sb.push_back(c);
    endtask

    task automatic t_wb(input string nm, input ResultSource_t res);
        cyc_t c;
        c = new_cyc({nm, ".wb"}, 1'b1, 1'b0, S_REGW);
        c.res_c = 1'b1; c.res = res;
        sb.push_back(c);
    endtask

    task automatic t_mem(input string nm, input logic rdy, input logic [5:0] strb);
        cyc_t c;
        c = new_cyc(nm, rdy, 1'b0, strb);
        c.adr_c = 1'b1; c.adr = ADR_ALUOUT;
        sb.push_back(c);
    endtask

    task automatic t_branch(input string nm, input logic z, input logic [5:0] strb);
        cyc_t c;
        c = new_cyc({nm, ".br"}, 1'b1, z, strb);
        c.alu_c = 1'b1; c.a = A_RD1; c.b = B_RD2; c.alu = ALU_SUB;
        c.res_c = 1'b1; c.res = RES_ALUOUT;
        sb.push_back(c);
    endtask

    task automatic t_jal(input string nm);
        cyc_t c;
        c = new_cyc({nm, ".jal"}, 1'b1, 1'b0, S_PCW);
        c.alu_c = 1'b1; c.a = A_OLDPC; c.b = B_FOUR; c.alu = ALU_ADD;
        c.res_c = 1'b1; c.res = RES_ALUOUT;
        sb.push_back(c);
    endtask

    task automatic t_rst(input string nm, input logic rdy);
        cyc_t c;
        c = new_cyc(nm, rdy, 1'b0, S_NONE);
        c.r = 1'b1;
        sb.push_back(c);
    endtask

    // Simple ALU-class instruction: fetch, decode, execute, write-back.
    task automatic t_arith(input string nm, input logic [31:0] instr, input ALUop_t alu);
        logic is_r;
        is_r = (instr[6:0] == OP_R);
        t_fetch(nm, instr, 0);
        t_dec(nm, S_NONE, !is_r, IMM_I);
        t_alu({nm, ".exec"}, S_NONE, A_RD1, is_r ? B_RD2 : B_IMM, alu);
        t_wb(nm, RES_ALUOUT);
    endtask

    task automatic run();
        cyc_t c;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            @(negedge clk);
            rst       = c.r;
            mem_ready = c.rdy;
            zero      = c.z;
            opcode    = c.ir[6:0];
            funct3    = c.ir[14:12];
            funct7    = c.ir[31:25];
            #1;
            check({c.nm, ".strb"},
                  {26'b0, mem_req, mem_write, ir_write, pc_write, reg_write, illegal},
                  {26'b0, c.strb});
            if (c.alu_c) begin
                check({c.nm, ".src_a"}, 32'(alu_src_a), 32'(c.a));
                check({c.nm, ".src_b"}, 32'(alu_src_b), 32'(c.b));
                check({c.nm, ".alu"}, 32'(alu_control), 32'(c.alu));
            end
            if (c.res_c) check({c.nm, ".res"}, 32'(result_src), 32'(c.res));
            if (c.adr_c) check({c.nm, ".adr"}, 32'(adr_src), 32'(c.adr));
            if (c.imm_c) check({c.nm, ".imm"}, 32'(imm_src), 32'(c.imm));
        end
    endtask

    initial begin
        // Reset held for two cycles, then the first fetch must request memory at PC.
        t_rst("rst0", 1'b1);
        t_rst("rst1", 1'b1);
        t_arith("add", 32'h002081B3, ALU_ADD);
        run();

        t_arith("sub",  mk(7'b0100000, 3'b000, OP_R), ALU_SUB);
        t_arith("srl",  mk(7'b0000000, 3'b101, OP_R), ALU_SRL);
        t_arith("srai", mk(7'b0100000, 3'b101, OP_I), ALU_SRA);
        t_arith("addi", mk(7'b0100000, 3'b000, OP_I), ALU_ADD);
        t_arith("xor",  mk(7'b0000000, 3'b100, OP_R), ALU_XOR);
        run();

        // R-type with an unsupported funct7: illegal in EXECR, straight back to FETCH.
        t_fetch("mul", mk(7'b0000001, 3'b000, OP_R), 0);
        t_dec("mul", S_NONE, 1'b0, IMM_I);
        t_alu("mul.exec", S_ILL, A_RD1, B_RD2, ALU_ADD);
        run();

        // lw with two wait states in MEMREAD: seven cycles end to end.
        t_fetch("lw", 32'h0000A103, 0);
        t_dec("lw", S_NONE, 1'b1, IMM_I);
        t_alu("lw.adr", S_NONE, A_RD1, B_IMM, ALU_ADD);
        t_mem("lw.rd0", 1'b0, S_REQ);
        t_mem("lw.rd1", 1'b0, S_REQ);
        t_mem("lw.rd2", 1'b1, S_REQ);
        t_wb("lw", RES_DATA);
        run();

        // sw with one fetch wait and one store wait.
        t_fetch("sw", mk(7'b0000000, 3'b010, OP_STORE), 1);
        t_dec("sw", S_NONE, 1'b1, IMM_S);
        t_alu("sw.adr", S_NONE, A_RD1, B_IMM, ALU_ADD);
        t_mem("sw.wr0", 1'b0, S_STORE);
        t_mem("sw.wr1", 1'b1, S_STORE);
        run();

        t_fetch("beq1", 32'h00000063, 0);
        t_dec("beq1", S_NONE, 1'b1, IMM_B);
        t_branch("beq1", 1'b1, S_PCW);
        t_fetch("bne1", 32'h00001063, 0);
        t_dec("bne1", S_NONE, 1'b1, IMM_B);
        t_branch("bne1", 1'b1, S_NONE);
        t_fetch("beq0", 32'h00000063, 0);
        t_dec("beq0", S_NONE, 1'b1, IMM_B);
        t_branch("beq0", 1'b0, S_NONE);
        t_fetch("bne0", 32'h00001063, 0);
        t_dec("bne0", S_NONE, 1'b1, IMM_B);
        t_branch("bne0", 1'b0, S_PCW);
        t_fetch("blt", mk(7'b0000000, 3'b100, OP_BRANCH), 0);
        t_dec("blt", S_NONE, 1'b1, IMM_B);
        t_branch("blt", 1'b1, S_ILL);
        run();

        t_fetch("jal", 32'h0000006F, 0);
        t_dec("jal", S_NONE, 1'b1, IMM_J);
        t_jal("jal");
        t_wb("jal", RES_ALUOUT);
        t_fetch("jalr", 32'h000080E7, 0);
        t_dec("jalr", S_NONE, 1'b1, IMM_I);
        t_alu("jalr.adr", S_NONE, A_RD1, B_IMM, ALU_ADD);
        t_jal("jalr");
        t_wb("jalr", RES_ALUOUT);
        run();

        // Unknown opcode, then a lw aborted by reset while waiting in MEMREAD.
        t_fetch("op7f", 32'h0000007F, 0);
        t_dec("op7f", S_ILL, 1'b0, IMM_I);
        t_fetch("lwab", 32'h0000A103, 0);
        t_dec("lwab", S_NONE, 1'b1, IMM_I);
        t_alu("lwab.adr", S_NONE, A_RD1, B_IMM, ALU_ADD);
        t_mem("lwab.rd0", 1'b0, S_REQ);
        t_rst("lwab.rst", 1'b1);
        t_arith("post", 32'h002081B3, ALU_ADD);
        run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
